// File: rtl/lzw_code_packer.sv
`default_nettype none
// ============================================================================
// Module      : lzw_code_packer
// Description : Packs CODE_W-bit LZW codes LSB-first into a byte stream, with
//               flush of the zero-padded tail. Optional LZW_PACKER_STATS_EN
//               adds accepted-code and transferred-byte counters.
// Revision    : 1.0 - initial release
// ============================================================================
module lzw_code_packer #(
    parameter int CODE_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] code_in,
    input  logic              code_valid,
    output logic              code_ready,
    input  logic              flush,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              flush_done
`ifdef LZW_PACKER_STATS_EN
    ,
    output logic [31:0]       code_count,
    output logic [31:0]       byte_count
`endif
);

    localparam int ACC_W = CODE_W + 7;
    localparam int CNT_W = $clog2(ACC_W + 1);
    localparam logic [CNT_W-1:0] c_code_w = CNT_W'(CODE_W);
    localparam logic [CNT_W-1:0] c_byte_w = CNT_W'(8);

    typedef enum logic [1:0] {
        PACK  = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [7:0]       w_mask_nxt;
    logic             w_accept;
    logic             w_xfer;

    // Handshake outputs are registered copies of functions of (state, cnt),
    // so they can drive the accept/transfer decisions directly.
    assign w_accept = code_valid && code_ready;
    assign w_xfer   = byte_valid && byte_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        if (w_accept) begin
            w_acc_nxt = r_acc | (ACC_W'(code_in) << r_cnt);
            w_cnt_nxt = r_cnt + c_code_w;
        end else if (w_xfer) begin
            w_acc_nxt = r_acc >> 8;
            w_cnt_nxt = (r_cnt > c_byte_w) ? (r_cnt - c_byte_w) : '0;
        end
        case (r_state)
            PACK:    if (flush) w_state_nxt = FLUSH;
            FLUSH:   if (w_cnt_nxt == '0) w_state_nxt = DONE;
            DONE: begin
                w_state_nxt = PACK;
                w_acc_nxt   = '0;
                w_cnt_nxt   = '0;
            end
            default: w_state_nxt = PACK;
        endcase
    end

    // Bits at or above cnt are forced low so the padded tail byte is clean.
    always_comb begin
        if (w_cnt_nxt >= c_byte_w) w_mask_nxt = 8'hFF;
        else                       w_mask_nxt = 8'((9'd1 << w_cnt_nxt) - 9'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= PACK;
            r_acc      <= '0;
            r_cnt      <= '0;
            code_ready <= 1'b0;
            byte_valid <= 1'b0;
            byte_out   <= 8'h00;
            flush_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_acc      <= w_acc_nxt;
            r_cnt      <= w_cnt_nxt;
            code_ready <= (w_state_nxt == PACK) && (w_cnt_nxt < c_byte_w);
            byte_valid <= (w_cnt_nxt >= c_byte_w) ||
                          ((w_state_nxt == FLUSH) && (w_cnt_nxt != '0));
            byte_out   <= w_acc_nxt[7:0] & w_mask_nxt;
            flush_done <= (w_state_nxt == DONE);
        end
    end

`ifdef LZW_PACKER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_count <= 32'd0;
            byte_count <= 32'd0;
        end else begin
            if (w_accept) code_count <= code_count + 32'd1;
            if (w_xfer)   byte_count <= byte_count + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_lzw_code_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lzw_code_packer
// Description : Directed and randomized bench for lzw_code_packer against a
//               bit-queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lzw_code_packer;

    localparam int CODE_W = 11;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [CODE_W-1:0] code_in = '0;
    logic              code_valid = 1'b0;
    logic              code_ready;
    logic              flush = 1'b0;
    logic [7:0]        byte_out;
    logic              byte_valid;
    logic              byte_ready = 1'b1;
    logic              flush_done;
`ifdef LZW_PACKER_STATS_EN
    logic [31:0]       code_count;
    logic [31:0]       byte_count;
`endif

    lzw_code_packer #(.CODE_W(CODE_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .code_in    (code_in),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .flush      (flush),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .flush_done (flush_done)
`ifdef LZW_PACKER_STATS_EN
        ,
        .code_count (code_count),
        .byte_count (byte_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed transfers and flush_done pulses, sampled mid-cycle.
    logic [7:0] got_q[$];
    int last_byte_cyc = 0;
    int done_cyc = 0;
    int done_cnt = 0;
    always @(negedge clk) begin
        if (rst_n && byte_valid && byte_ready) begin
            got_q.push_back(byte_out);
            last_byte_cyc = cyc;
        end
        if (rst_n && flush_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    bit rand_bp = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rand_bp) byte_ready = ($urandom_range(0, 3) != 0);
    end

    // Reference model: the stream is just a queue of bits, cut into bytes.
    bit         mbits[$];
    logic [7:0] exp_q[$];

    function automatic void model_emit();
        while (mbits.size() >= 8) begin
            logic [7:0] b;
            for (int i = 0; i < 8; i++) b[i] = mbits.pop_front();
            exp_q.push_back(b);
        end
    endfunction

    function automatic void model_code(input logic [CODE_W-1:0] c);
        for (int i = 0; i < CODE_W; i++) mbits.push_back(c[i]);
        model_emit();
    endfunction

    function automatic void model_flush();
        if (mbits.size() > 0) begin
            while (mbits.size() < 8) mbits.push_back(1'b0);
            model_emit();
        end
    endfunction

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int flush_cyc = 0;

    task automatic send_code(input logic [CODE_W-1:0] c, input bit with_flush);
        bit ok = 1'b0;
        code_in    = c;
        code_valid = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (code_ready) begin
                ok = 1'b1;
                if (with_flush) begin
                    flush = 1'b1;
                    flush_cyc = cyc;
                end
            end
            tick();
        end
        code_valid = 1'b0;
        flush      = 1'b0;
        check("accept_timeout", 32'(ok), 32'd1);
        if (ok) begin
            model_code(c);
            if (with_flush) model_flush();
        end
    endtask

    task automatic do_flush();
        flush     = 1'b1;
        flush_cyc = cyc;
        tick();
        flush     = 1'b0;
        model_flush();
    endtask

    task automatic wait_done(input int base);
        int n = 0;
        while (done_cnt == base && n < 400) begin
            tick();
            n++;
        end
        check("flush_done_seen", 32'(done_cnt), 32'(base + 1));
    endtask

    task automatic compare_bytes(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < got_q.size()) check(tag, 32'(got_q[i]), 32'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int base;
        logic [7:0] held;

        // Reset state and first-edge release behaviour.
        #12;
        check("rst_code_ready", 32'(code_ready), 32'd0);
        check("rst_byte_valid", 32'(byte_valid), 32'd0);
        check("rst_flush_done", 32'(flush_done), 32'd0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        #1;
        check("release_code_ready_pre_edge", 32'(code_ready), 32'd0);
        tick();
        check("release_code_ready_post_edge", 32'(code_ready), 32'd1);
        check("release_byte_valid", 32'(byte_valid), 32'd0);

        // 0x7FF, 0x001, flush -> FF 0F 00.
        base = done_cnt;
        send_code(11'h7FF, 1'b0);
        send_code(11'h001, 1'b0);
        do_flush();
        wait_done(base);
        check("seq1_exp_len", 32'(exp_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            check("seq1_b0", 32'(got_q[0]), 32'hFF);
            check("seq1_b1", 32'(got_q[1]), 32'h0F);
            check("seq1_b2", 32'(got_q[2]), 32'h00);
        end
        compare_bytes("seq1");
`ifdef LZW_PACKER_STATS_EN
        check("stats_code_count", code_count, 32'd2);
        check("stats_byte_count", byte_count, 32'd3);
`endif
        tick();
        tick();
        check("flush_done_single_pulse", 32'(done_cnt), 32'(base + 1));

        // 0x123 then flush -> 23 01, done the cycle after the last byte.
        base = done_cnt;
        send_code(11'h123, 1'b0);
        do_flush();
        wait_done(base);
        check("seq2_done_latency", 32'(done_cyc), 32'(last_byte_cyc + 1));
        compare_bytes("seq2");

        // Eight 0x555 codes -> 11 bytes; empty flush -> no byte, done 2 cycles on.
        for (int i = 0; i < 8; i++) send_code(11'h555, 1'b0);
        repeat (4) tick();
        check("seq3_byte_count", 32'(got_q.size()), 32'd11);
        check("seq3_ready_idle", 32'(code_ready), 32'd1);
        base = done_cnt;
        do_flush();
        wait_done(base);
        check("seq3_done_latency", 32'(done_cyc), 32'(flush_cyc + 2));
        check("seq3_no_extra_byte", 32'(got_q.size()), 32'd11);
        compare_bytes("seq3");

        // Backpressure: output holds for 5 stalled cycles, nothing lost.
        byte_ready = 1'b0;
        send_code(11'h7FF, 1'b0);
        @(negedge clk);
        check("bp_valid_rise", 32'(byte_valid), 32'd1);
        check("bp_first_byte", 32'(byte_out), 32'(exp_q[0]));
        held = byte_out;
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(byte_valid), 32'd1);
            check("bp_hold_data", 32'(byte_out), 32'(held));
            check("bp_hold_ready", 32'(code_ready), 32'd0);
            tick();
        end
        byte_ready = 1'b1;
        base = done_cnt;
        do_flush();
        wait_done(base);
        compare_bytes("bp");

        // Reset while flushing a 5-bit remainder.
        for (int i = 0; i < 7; i++) send_code(CODE_W'($urandom), 1'b0);
        repeat (4) tick();
        compare_bytes("pre_rst");
        check("pre_rst_remainder", 32'(mbits.size()), 32'd5);
        byte_ready = 1'b0;
        base = done_cnt;
        do_flush();
        tick();
        @(negedge clk);
        check("mid_flush_valid", 32'(byte_valid), 32'd1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(byte_valid), 32'd0);
        check("async_rst_ready", 32'(code_ready), 32'd0);
        check("async_rst_done", 32'(flush_done), 32'd0);
        mbits.delete();
        exp_q.delete();
        got_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b1;
        byte_ready = 1'b1;
        tick();
        check("post_rst_ready", 32'(code_ready), 32'd1);
        check("post_rst_no_done", 32'(done_cnt), 32'(base));
        send_code(11'h000, 1'b0);
        do_flush();
        wait_done(base);
        check("post_rst_len", 32'(got_q.size()), 32'd2);
        compare_bytes("post_rst");

        // Randomized codes with random backpressure and flush placement.
        for (int r = 0; r < 20; r++) begin
            int  n;
            bit  fl_with;
            n = $urandom_range(1, 6);
            fl_with = $urandom_range(0, 1) == 1;
            base = done_cnt;
            rand_bp = 1'b1;
            for (int k = 0; k < n; k++)
                send_code(CODE_W'($urandom), (k == n - 1) && fl_with);
            if (!fl_with) do_flush();
            wait_done(base);
            rand_bp = 1'b0;
            byte_ready = 1'b1;
            tick();
            compare_bytes("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/lzw_code_packer.md
LZW_CODE_PACKER -- requirements
Module: lzw_code_packer

Interface
REQ-001 Parameter CODE_W, default 11, LZW code width in bits; legal range 9..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 code_in  input  CODE_W  LZW code from the dictionary stage.
REQ-005 code_valid  input  1  code_in holds a valid code.
REQ-006 code_ready  output  1  packer accepts code_in this cycle.
REQ-007 flush  input  1  single-cycle end-of-stream request.
REQ-008 byte_out  output  8  packed byte; drives the data_in port of the 64-bit byte shift register.
REQ-009 byte_valid  output  1  byte_out is valid; used as that register's shift strobe.
REQ-010 byte_ready  input  1  downstream consumes byte_out this cycle; tie high when there is no backpressure.
REQ-011 flush_done  output  1  one-cycle pulse when the flush has completed.

Function
REQ-012 Accumulator acc is CODE_W+7 bits wide, with bit count cnt in 0..CODE_W+7; codes are packed LSB-first.
REQ-013 A code is accepted when code_valid && code_ready: acc <= acc | (code_in << cnt), cnt <= cnt+CODE_W.
REQ-014 code_ready = 1 only in state PACK with cnt < 8, and is 0 in all other states.
REQ-015 byte_valid = 1 when cnt >= 8, or in state FLUSH with cnt > 0; byte_out = acc[7:0] with bits at or above cnt forced to 0.
REQ-016 A byte is transferred when byte_valid && byte_ready: acc <= acc >> 8, cnt <= cnt-8, saturating at 0 (the final partial byte leaves cnt at 0).
REQ-017 Accept and transfer are mutually exclusive by construction (cnt < 8 versus cnt >= 8); no simultaneous update path.
REQ-018 While byte_valid is high and byte_ready is low, byte_out and byte_valid hold stable.
REQ-019 Latency: byte_valid rises on the cycle after the accepting edge.
REQ-020 Throughput: one code per 2 cycles when 1 byte is emitted, and per 3 cycles when 2 bytes are emitted.
REQ-021 State PACK: flush sampled high -> FLUSH; flush and an accept in the same cycle -> the code is accepted first, then FLUSH.
REQ-022 State FLUSH: code_ready = 0; remaining full bytes are emitted, then the zero-padded partial byte if cnt > 0; when cnt reaches 0 -> DONE.
REQ-023 State DONE: flush_done = 1 for exactly one cycle, then -> PACK with acc = 0 and cnt = 0.
REQ-024 flush with cnt = 0 goes PACK -> FLUSH -> DONE and emits no byte, so flush_done is asserted 2 cycles after the flush.
REQ-025 flush asserted outside PACK is ignored.

Reset
REQ-026 rst_n low asynchronously forces state = PACK, acc = 0, cnt = 0, byte_valid = 0, flush_done = 0, code_ready = 0.
REQ-027 code_ready may rise only after the first rising clk edge following rst_n deassertion.
REQ-028 Reset mid-stream discards partial data with no flush_done; outputs recover within 1 cycle.

Configuration
REQ-029 Macro LZW_PACKER_STATS_EN defined: add output code_count[31:0] (accepted codes) and output byte_count[31:0] (transferred bytes).
REQ-030 Both counters wrap at 2^32, are cleared by rst_n, and are not cleared by flush.
REQ-031 Macro LZW_PACKER_STATS_EN undefined: neither port nor counter exists, and functional behaviour is identical.

Verification
REQ-032 CODE_W = 11, byte_ready = 1; codes 0x7FF then 0x001, then flush -> bytes 0xFF, 0x0F, 0x00, followed by a flush_done pulse.
REQ-033 Code 0x123 then flush -> bytes 0x23, 0x01; flush_done asserted the cycle after the last byte.
REQ-034 Eight codes of 0x555 with byte_ready = 1 -> exactly 11 bytes (88 bits) and cnt = 0; flush then produces no byte, and flush_done is asserted 2 cycles after the flush.
REQ-035 byte_ready held low 5 cycles with byte_valid = 1 -> byte_out stable, code_ready = 0, no byte lost when ready returns.
REQ-036 Assert rst_n low mid-FLUSH with cnt = 5 -> byte_valid = 0 immediately; after release, code 0x000 plus flush -> bytes 0x00, 0x00 only.
REQ-037 With LZW_PACKER_STATS_EN defined, REQ-032 stimulus -> code_count = 2, byte_count = 3.
